wb_rr_arbiter: RTL and testbench
================================

WB_RR_ARBITER -- requirements
Module: wb_rr_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 16: cycles a waiting master tolerates before forced handover.
REQ-002 SHALL have parameter ADR_W, default 32: address width of all address ports.
REQ-003 SHALL have ports:
  wb_clk_i  in  1  sole clock; all state updates on rising edge
  wb_rst_i  in  1  reset, synchronous, active-high
  cpu_stb_i, cpu_cyc_i, cpu_we_i  in  1 each  CPU Wishbone request
  cpu_sel_i  in  4  CPU byte enables
  cpu_adr_i  in  ADR_W  CPU address
  cpu_dat_i  in  32  CPU write data
  cpu_ack_o  out  1  CPU ack
  cpu_dat_o  out  32  CPU read data
  dma_stb_i, dma_cyc_i, dma_we_i, dma_sel_i, dma_adr_i, dma_dat_i  in  as CPU  DMA request
  dma_ack_o  out  1  DMA ack
  dma_dat_o  out  32  DMA read data
  mem_stb_o, mem_cyc_o, mem_we_o  out  1 each  to SDRAM controller
  mem_sel_o  out  4;  mem_adr_o  out  ADR_W;  mem_dat_o  out  32
  mem_ack_i  in  1;  mem_dat_i  in  32  controller response
  gnt_o  out  2  one-hot grant status, bit0 CPU, bit1 DMA

Function
REQ-004 SHALL implement states IDLE, GNT_CPU, GNT_DMA, TURN.
REQ-005 SHALL define request as stb&cyc of a master.
REQ-006 IDLE: one request -> grant that master next cycle; both -> grant master not granted last (round robin); none -> stay.
REQ-007 SHALL initialise last-granted to DMA so CPU wins the first tie after reset.
REQ-008 SHALL give one-cycle arbitration latency: request seen in IDLE at edge N, mem_stb_o asserted from cycle N+1.
REQ-009 In GNT_x SHALL forward granted master's stb/cyc/we/sel/adr/dat combinationally to mem_*; non-granted master sees ack=0.
REQ-010 SHALL route mem_ack_i to granted master's ack only while its stb&cyc is high; mem_dat_i SHALL drive both *_dat_o, qualified only by ack.
REQ-011 SHALL hold grant across back-to-back transfers while granted master keeps cyc high (burst lock).
REQ-012 Granted master dropping cyc -> TURN; TURN lasts exactly one cycle with all mem_* = 0, then IDLE.
REQ-013 Grant SHALL never change while mem_stb_o=1 and ack not yet received.
REQ-014 mem_stb_o/mem_cyc_o SHALL be 0 in IDLE and TURN; gnt_o=0 in IDLE and TURN.
REQ-015 Ack and cyc drop in the same cycle SHALL count as a completed transfer, then TURN.

Reset
REQ-016 wb_rst_i high at an edge SHALL force IDLE, last-granted=DMA, starve counter=0, regardless of transfer in progress.
REQ-017 During and after reset all outputs SHALL be 0 until a new grant.

Configuration
REQ-018 Macro WB_ARB_STARVE_GUARD_EN defined: counter increments each cycle non-granted master requests during GNT_x; at STARVE_LIMIT, after the current master's next ack, SHALL go to TURN and grant the waiting master, even if current cyc remains high.
REQ-019 Macro undefined: no counter; burst lock held until cyc drops.
REQ-020 Counter SHALL clear on every grant change and saturate at STARVE_LIMIT.

Structure
REQ-021 Shared package wb_arb_pkg SHALL hold state enum, master-ID constants (CPU=0, DMA=1) and default STARVE_LIMIT.
REQ-022 Starve counter SHALL be sub-module wb_arb_starve_cnt, instantiated only under WB_ARB_STARVE_GUARD_EN.

Verification
REQ-023 CPU and DMA request same cycle after reset -> gnt_o=01 next cycle; DMA acked only after CPU cyc drop + 1 TURN cycle.
REQ-024 CPU single write adr 0x3800_0010, dat 0xA5A5_5A5A -> mem_adr_o/mem_dat_o match at N+1; cpu_ack_o mirrors mem_ack_i; dma_ack_o stays 0.
REQ-025 Alternating simultaneous requests, 4 rounds -> grants CPU, DMA, CPU, DMA.
REQ-026 Guard enabled, STARVE_LIMIT=4, CPU holds cyc for 20 acks, DMA waiting -> CPU loses grant after first ack with counter=4; DMA granted after TURN.
REQ-027 Reset mid-burst while gnt_o=10 -> next cycle all outputs 0, state IDLE; subsequent tie goes to CPU.
REQ-028 Granted master drops stb before ack while mem_ack_i pulses -> master ack stays 0, no grant change.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the two-master Wishbone round-robin arbiter.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GNT_CPU = 2'd1,
    ST_GNT_DMA = 2'd2,
    ST_TURN    = 2'd3
  } arb_state_e;

  localparam logic MST_CPU = 1'b0;
  localparam logic MST_DMA = 1'b1;

  localparam int unsigned STARVE_LIMIT_DEF = 16;

endpackage

// File: rtl/wb_arb_starve_cnt.sv
// Saturating wait counter for the non-granted master; hit_o flags that the
// waiting master has been starved for LIMIT granted cycles.
module wb_arb_starve_cnt #(
  parameter int unsigned LIMIT = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic inc_i,
  output logic hit_o
);

  localparam int unsigned CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != CW'(LIMIT))) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign hit_o = (cnt_q == CW'(LIMIT));

endmodule

// File: rtl/wb_rr_arbiter.sv
// Two-master (CPU/DMA) Wishbone round-robin arbiter in front of the SDRAM port.
// Define WB_ARB_STARVE_GUARD_EN to force handover after STARVE_LIMIT waiting cycles.
module wb_rr_arbiter
  import wb_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF,
  parameter int unsigned ADR_W        = 32
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             cpu_stb_i,
  input  logic             cpu_cyc_i,
  input  logic             cpu_we_i,
  input  logic [3:0]       cpu_sel_i,
  input  logic [ADR_W-1:0] cpu_adr_i,
  input  logic [31:0]      cpu_dat_i,
  output logic             cpu_ack_o,
  output logic [31:0]      cpu_dat_o,
  input  logic             dma_stb_i,
  input  logic             dma_cyc_i,
  input  logic             dma_we_i,
  input  logic [3:0]       dma_sel_i,
  input  logic [ADR_W-1:0] dma_adr_i,
  input  logic [31:0]      dma_dat_i,
  output logic             dma_ack_o,
  output logic [31:0]      dma_dat_o,
  output logic             mem_stb_o,
  output logic             mem_cyc_o,
  output logic             mem_we_o,
  output logic [3:0]       mem_sel_o,
  output logic [ADR_W-1:0] mem_adr_o,
  output logic [31:0]      mem_dat_o,
  input  logic             mem_ack_i,
  input  logic [31:0]      mem_dat_i,
  output logic [1:0]       gnt_o
);

  if (STARVE_LIMIT < 1) begin : g_limit_chk
    $error("STARVE_LIMIT must be at least 1");
  end

  arb_state_e state_q, state_d;
  logic       last_q, last_d;
  logic       cpu_req, dma_req;
  logic       starve_hit;

  assign cpu_req = cpu_stb_i & cpu_cyc_i;
  assign dma_req = dma_stb_i & dma_cyc_i;

`ifdef WB_ARB_STARVE_GUARD_EN
  logic starve_inc, starve_clr;

  assign starve_inc = ((state_q == ST_GNT_CPU) && dma_req) ||
                      ((state_q == ST_GNT_DMA) && cpu_req);
  // Any non-granted state sits between two grants, so it clears the count.
  assign starve_clr = (state_q == ST_IDLE) || (state_q == ST_TURN);

  wb_arb_starve_cnt #(.LIMIT(STARVE_LIMIT)) u_starve_cnt (
    .clk_i (wb_clk_i),
    .rst_i (wb_rst_i),
    .clr_i (starve_clr),
    .inc_i (starve_inc),
    .hit_o (starve_hit)
  );
`else
  assign starve_hit = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    mem_stb_o = 1'b0;
    mem_cyc_o = 1'b0;
    mem_we_o  = 1'b0;
    mem_sel_o = '0;
    mem_adr_o = '0;
    mem_dat_o = '0;
    gnt_o     = 2'b00;
    cpu_ack_o = 1'b0;
    dma_ack_o = 1'b0;
    cpu_dat_o = '0;
    dma_dat_o = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (cpu_req && (!dma_req || (last_q == MST_DMA))) begin
          state_d = ST_GNT_CPU;
          last_d  = MST_CPU;
        end else if (dma_req) begin
          state_d = ST_GNT_DMA;
          last_d  = MST_DMA;
        end
      end
      ST_GNT_CPU: begin
        mem_stb_o = cpu_stb_i;
        mem_cyc_o = cpu_cyc_i;
        mem_we_o  = cpu_we_i;
        mem_sel_o = cpu_sel_i;
        mem_adr_o = cpu_adr_i;
        mem_dat_o = cpu_dat_i;
        gnt_o     = 2'b01;
        cpu_ack_o = cpu_req & mem_ack_i;
        cpu_dat_o = mem_ack_i ? mem_dat_i : '0;
        dma_dat_o = mem_ack_i ? mem_dat_i : '0;
        if (!cpu_cyc_i || (starve_hit && cpu_ack_o)) begin
          state_d = ST_TURN;
        end
      end
      ST_GNT_DMA: begin
        mem_stb_o = dma_stb_i;
        mem_cyc_o = dma_cyc_i;
        mem_we_o  = dma_we_i;
        mem_sel_o = dma_sel_i;
        mem_adr_o = dma_adr_i;
        mem_dat_o = dma_dat_i;
        gnt_o     = 2'b10;
        dma_ack_o = dma_req & mem_ack_i;
        cpu_dat_o = mem_ack_i ? mem_dat_i : '0;
        dma_dat_o = mem_ack_i ? mem_dat_i : '0;
        if (!dma_cyc_i || (starve_hit && dma_ack_o)) begin
          state_d = ST_TURN;
        end
      end
      ST_TURN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
      last_q  <= MST_DMA;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed self-checking bench for wb_rr_arbiter; the starvation scenario
// follows WB_ARB_STARVE_GUARD_EN the same way the design does.
module tb_wb_rr_arbiter;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i;
  logic        cpu_stb, cpu_cyc, cpu_we;
  logic [3:0]  cpu_sel;
  logic [31:0] cpu_adr, cpu_dat;
  logic        cpu_ack;
  logic [31:0] cpu_dat_o;
  logic        dma_stb, dma_cyc, dma_we;
  logic [3:0]  dma_sel;
  logic [31:0] dma_adr, dma_dat;
  logic        dma_ack;
  logic [31:0] dma_dat_o;
  logic        mem_stb, mem_cyc, mem_we;
  logic [3:0]  mem_sel;
  logic [31:0] mem_adr, mem_dat_o;
  logic        mem_ack;
  logic [31:0] mem_dat_i;
  logic [1:0]  gnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 wb_clk_i = ~wb_clk_i;

  wb_rr_arbiter #(.STARVE_LIMIT(4), .ADR_W(32)) dut (
    .wb_clk_i  (wb_clk_i),
    .wb_rst_i  (wb_rst_i),
    .cpu_stb_i (cpu_stb),
    .cpu_cyc_i (cpu_cyc),
    .cpu_we_i  (cpu_we),
    .cpu_sel_i (cpu_sel),
    .cpu_adr_i (cpu_adr),
    .cpu_dat_i (cpu_dat),
    .cpu_ack_o (cpu_ack),
    .cpu_dat_o (cpu_dat_o),
    .dma_stb_i (dma_stb),
    .dma_cyc_i (dma_cyc),
    .dma_we_i  (dma_we),
    .dma_sel_i (dma_sel),
    .dma_adr_i (dma_adr),
    .dma_dat_i (dma_dat),
    .dma_ack_o (dma_ack),
    .dma_dat_o (dma_dat_o),
    .mem_stb_o (mem_stb),
    .mem_cyc_o (mem_cyc),
    .mem_we_o  (mem_we),
    .mem_sel_o (mem_sel),
    .mem_adr_o (mem_adr),
    .mem_dat_o (mem_dat_o),
    .mem_ack_i (mem_ack),
    .mem_dat_i (mem_dat_i),
    .gnt_o     (gnt)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_stb = 0; cpu_cyc = 0; cpu_we = 0; cpu_sel = 4'h0; cpu_adr = '0; cpu_dat = '0;
    dma_stb = 0; dma_cyc = 0; dma_we = 0; dma_sel = 4'h0; dma_adr = '0; dma_dat = '0;
    mem_ack = 0; mem_dat_i = '0;
  endtask

  task automatic do_reset();
    wb_rst_i = 1;
    tick();
    tick();
    wb_rst_i = 0;
  endtask

  // One 0-vs-all-outputs snapshot, used for reset and non-granted states.
  task automatic chk_quiet(input string tag);
    chk({tag, "_gnt"}, 64'(gnt), 64'h0);
    chk({tag, "_bus"}, {mem_stb, mem_cyc, mem_we, mem_sel, mem_adr[15:0]}, 64'h0);
    chk({tag, "_ack"}, {cpu_ack, dma_ack}, 64'h0);
    chk({tag, "_dat"}, {cpu_dat_o, dma_dat_o}, 64'h0);
  endtask

  logic [1:0] g4, g5, g7, g19;
  int         cpu_acks;
  logic [1:0] exp_rr [4];

  initial begin
    idle_inputs();
    wb_rst_i = 1;
    // Requests and a stray ack during reset must not leak to any output.
    cpu_stb = 1; cpu_cyc = 1; mem_ack = 1; mem_dat_i = 32'hDEAD_BEEF;
    tick();
    tick();
    chk_quiet("in_reset");
    idle_inputs();
    wb_rst_i = 0;
    #1;
    chk_quiet("after_reset");

    // CPU single write: request in IDLE, bus driven from the next cycle.
    cpu_stb = 1; cpu_cyc = 1; cpu_we = 1; cpu_sel = 4'hF;
    cpu_adr = 32'h3800_0010; cpu_dat = 32'hA5A5_5A5A;
    #1;
    chk("wr_lat0_stb", 64'(mem_stb), 64'h0);
    tick();
    chk("wr_gnt", 64'(gnt), 64'h1);
    chk("wr_adr", 64'(mem_adr), 64'h3800_0010);
    chk("wr_dat", 64'(mem_dat_o), 64'hA5A5_5A5A);
    chk("wr_ctl", {mem_stb, mem_cyc, mem_we, mem_sel}, 64'h7F);
    chk("wr_noack", {cpu_ack, dma_ack}, 64'h0);
    mem_ack = 1; mem_dat_i = 32'h1234_5678;
    #1;
    chk("wr_ack", {cpu_ack, dma_ack}, 64'h2);
    chk("wr_rdat", {cpu_dat_o, dma_dat_o}, 64'h1234_5678_1234_5678);
    tick();
    // Ack and cyc drop together: transfer done, then one TURN cycle.
    idle_inputs();
    #1;
    chk("wr_drop_gnt", 64'(gnt), 64'h1);
    tick();
    chk_quiet("wr_turn");
    tick();
    chk("wr_idle_gnt", 64'(gnt), 64'h0);

    // Simultaneous requests after reset: CPU first, DMA after CPU drop + TURN.
    do_reset();
    cpu_stb = 1; cpu_cyc = 1; cpu_adr = 32'h100;
    dma_stb = 1; dma_cyc = 1; dma_adr = 32'h200;
    tick();
    chk("tie_gnt_cpu", 64'(gnt), 64'h1);
    chk("tie_adr_cpu", 64'(mem_adr), 64'h100);
    mem_ack = 1;
    #1;
    chk("tie_acks_cpu", {cpu_ack, dma_ack}, 64'h2);
    tick();
    cpu_stb = 0; cpu_cyc = 0; mem_ack = 0;
    tick();
    mem_ack = 1;
    #1;
    chk("tie_turn_gnt", 64'(gnt), 64'h0);
    chk("tie_turn_dmaack", 64'(dma_ack), 64'h0);
    mem_ack = 0;
    tick();
    chk("tie_idle_gnt", 64'(gnt), 64'h0);
    tick();
    chk("tie_gnt_dma", 64'(gnt), 64'h2);
    chk("tie_adr_dma", 64'(mem_adr), 64'h200);
    mem_ack = 1;
    #1;
    chk("tie_acks_dma", {cpu_ack, dma_ack}, 64'h1);

    // Reset mid-burst while DMA owns the bus; CPU also requesting.
    cpu_stb = 1; cpu_cyc = 1;
    wb_rst_i = 1;
    tick();
    chk_quiet("mid_rst");
    wb_rst_i = 0;
    tick();
    chk("post_rst_tie", 64'(gnt), 64'h1);
    idle_inputs();
    tick();
    tick();

    // Alternating simultaneous requests.
    do_reset();
    exp_rr[0] = 2'b01; exp_rr[1] = 2'b10; exp_rr[2] = 2'b01; exp_rr[3] = 2'b10;
    for (int r = 0; r < 4; r++) begin
      cpu_stb = 1; cpu_cyc = 1; dma_stb = 1; dma_cyc = 1;
      tick();
      chk($sformatf("rr_round%0d", r), 64'(gnt), 64'(exp_rr[r]));
      idle_inputs();
      tick();
      chk($sformatf("rr_turn%0d", r), 64'(gnt), 64'h0);
      tick();
    end

    // Granted master drops stb (keeps cyc) while memory pulses ack.
    cpu_stb = 1; cpu_cyc = 1;
    tick();
    chk("stb_gnt", 64'(gnt), 64'h1);
    cpu_stb = 0; mem_ack = 1;
    #1;
    chk("stb_drop_ack", {cpu_ack, dma_ack}, 64'h0);
    tick();
    mem_ack = 0;
    #1;
    chk("stb_drop_hold", 64'(gnt), 64'h1);
    idle_inputs();
    tick();
    tick();

    // CPU burst with DMA waiting and memory acking every cycle.
    do_reset();
    cpu_stb = 1; cpu_cyc = 1; dma_stb = 1; dma_cyc = 1; mem_ack = 1;
    tick();
    cpu_acks = 0;
    g4 = 2'b00; g5 = 2'b00; g7 = 2'b00; g19 = 2'b00;
    for (int k = 0; k < 20; k++) begin
      if (k < 7 && cpu_ack) cpu_acks++;
      if (k == 4) g4 = gnt;
      if (k == 5) g5 = gnt;
      if (k == 7) g7 = gnt;
      if (k == 19) g19 = gnt;
      tick();
    end
`ifdef WB_ARB_STARVE_GUARD_EN
    chk("starve_k4_gnt", 64'(g4), 64'h1);
    chk("starve_k5_turn", 64'(g5), 64'h0);
    chk("starve_k7_dma", 64'(g7), 64'h2);
    chk("starve_cpu_acks", 64'(cpu_acks), 64'd5);
`else
    chk("lock_k4_gnt", 64'(g4), 64'h1);
    chk("lock_k5_gnt", 64'(g5), 64'h1);
    chk("lock_k19_gnt", 64'(g19), 64'h1);
    chk("lock_cpu_acks", 64'(cpu_acks), 64'd7);
`endif
    idle_inputs();
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
